synthesijer_test_runner: RTL

- Synthesizable sequencer upstream of one or more Synthesijer-generated test modules.
- Drives each module's method handshake: `<m>_req` out, `<m>_busy` and `<m>_return` in.
- Runs tests in index order after a start delay and enforces a per-test watchdog.
- Collects pass/timeout flags for a thin simulation top or an on-board LED/UART reporter.

---
 rtl/synthesijer_test_runner_pkg.sv | 11 +
 rtl/synthesijer_test_runner_if.sv | 8 +
 rtl/synthesijer_test_runner_sat_counter.sv | 14 +
 rtl/synthesijer_test_runner.sv | 90 +++++++++
 4 files changed

// File: rtl/synthesijer_test_runner_pkg.sv
// synthesijer_test_pkg: runner state encoding, index width and mask helper shared by the runner files
package synthesijer_test_pkg;
  typedef enum logic [2:0] {IDLE, DELAY, REQ, WAIT_BUSY, TIMEOUT_ST, NEXT, DONE} state_t;
  localparam int IDX_W = 8;
  localparam int MAX_TESTS = 64;
  function automatic logic all_ones(input logic [MAX_TESTS-1:0] mask, input int n);
    logic [MAX_TESTS-1:0] valid;
    valid = (n >= MAX_TESTS) ? '1 : ((MAX_TESTS'(1) << n) - MAX_TESTS'(1));
    return (mask & valid) == valid;
  endfunction
endpackage

// File: rtl/synthesijer_test_runner_if.sv
// synthesijer_test_runner_if: method handshake bundle between the runner and the test modules
interface synthesijer_test_runner_if #(parameter int NUM_TESTS = 4);
  logic [NUM_TESTS-1:0] test_req;
  logic [NUM_TESTS-1:0] test_busy;
  logic [NUM_TESTS-1:0] test_return;
  modport master(output test_req, input test_busy, test_return);
  modport slave(input test_req, output test_busy, test_return);
endinterface

// File: rtl/synthesijer_test_runner_sat_counter.sv
// sat_counter: up counter with synchronous clear and enable that sticks at all-ones
module sat_counter #(parameter int W = 32) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  // clear wins over count; counting stops once every bit is set
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (clr) q <= '0;
    else if (en && !(&q)) q <= q + W'(1);
endmodule

// File: rtl/synthesijer_test_runner.sv
// synthesijer_test_runner: sequences Synthesijer method handshakes in order with a per-test watchdog
module synthesijer_test_runner
  import synthesijer_test_pkg::*;
#(
  parameter int NUM_TESTS   = 4,
  parameter int START_DELAY = 100,
  parameter int TIMEOUT     = 10000,
  parameter int CNT_W       = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  synthesijer_test_runner_if.master bus,
  output logic [IDX_W-1:0]          cur_index,
  output logic [NUM_TESTS-1:0]      pass_mask,
  output logic [NUM_TESTS-1:0]      timeout_mask,
  output logic [CNT_W-1:0]          cycle_count,
  output logic                      running,
  output logic                      done,
  output logic                      pass
);
  if (NUM_TESTS < 1 || NUM_TESTS > MAX_TESTS) begin : g_bad_num_tests
    $error("NUM_TESTS must be in 1..64");
  end
  if (TIMEOUT < 1 || (CNT_W < 63 && longint'(TIMEOUT) >= (longint'(1) << CNT_W))) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1 and below 2**CNT_W");
  end
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(START_DELAY > 0 ? START_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TESTS - 1);
  state_t state, state_n;
  logic [IDX_W-1:0] idx_n;
  logic [NUM_TESTS-1:0] sel, sel_n;
  logic [CNT_W-1:0] delay_q, wd_q;
  logic go, busy_cur, wd_hit, last;
  assign sel      = NUM_TESTS'(1) << cur_index;
  assign sel_n    = NUM_TESTS'(1) << idx_n;
  assign go       = (state == IDLE || state == DONE) && start;
  assign busy_cur = |(bus.test_busy & sel);
  assign wd_hit   = wd_q >= TO_LAST;
  assign last     = cur_index == LAST_IDX;
  sat_counter #(.W(CNT_W)) u_delay (
    .clk(clk), .reset(reset), .clr(go), .en(state == DELAY), .q(delay_q)
  );
  sat_counter #(.W(CNT_W)) u_watchdog (
    .clk(clk), .reset(reset), .clr(go || state == NEXT),
    .en(state == REQ || state == WAIT_BUSY), .q(wd_q)
  );
  sat_counter #(.W(CNT_W)) u_cycles (
    .clk(clk), .reset(reset), .clr(go),
    .en(state != IDLE && state != DONE), .q(cycle_count)
  );
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // next state and next index; an ack beats a watchdog expiry in the same cycle
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = start ? DELAY : state;
      DELAY:      state_n = delay_q >= DLY_LAST ? REQ : DELAY;
      REQ:        state_n = busy_cur ? WAIT_BUSY : wd_hit ? TIMEOUT_ST : REQ;
      WAIT_BUSY:  state_n = !busy_cur ? NEXT : wd_hit ? TIMEOUT_ST : WAIT_BUSY;
      TIMEOUT_ST: state_n = NEXT;
      NEXT:       state_n = last ? DONE : REQ;
      default:    state_n = IDLE;
    endcase
    idx_n = go ? '0 : (state == NEXT && !last) ? cur_index + IDX_W'(1) : cur_index;
  end
  // registered outputs derived from the upcoming state so they line up with it
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cur_index    <= '0;
      bus.test_req <= '0;
      pass_mask    <= '0;
      timeout_mask <= '0;
      running      <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
    end else begin
      cur_index    <= idx_n;
      bus.test_req <= state_n == REQ ? sel_n : '0;
      pass_mask    <= go ? '0 : (state == WAIT_BUSY && !busy_cur) ? pass_mask | (bus.test_return & sel) : pass_mask;
      timeout_mask <= go ? '0 : state == TIMEOUT_ST ? timeout_mask | sel : timeout_mask;
      running      <= state_n != IDLE && state_n != DONE;
      done         <= state_n == DONE;
      pass         <= state_n == DONE && all_ones(MAX_TESTS'(pass_mask), NUM_TESTS);
    end
endmodule
